// File: rtl/systolic_result_drain.sv
// rtl/systolic_result_drain.sv - snapshot the systolic result matrix and stream it out one row per beat
// Optional signed saturation of each streamed element: define SYSTOLIC_DRAIN_SAT_EN.
module systolic_result_drain #(
    parameter int ROWS      = 64,
    parameter int COLS      = 64,
    parameter int OP_WIDTH  = 48,
    parameter int OUT_WIDTH = 32
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         compute_done,
    input  logic [ROWS*COLS*OP_WIDTH-1:0]                output_matrix,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [COLS*OUT_WIDTH-1:0]                    out_data,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]   out_row,
    output logic                                         out_last,
    output logic                                         busy,
    output logic                                         drop_err,
    output logic                                         sat_seen
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic {IDLE, DRAIN} state_e;

    state_e                     state_q, state_d;
    logic                       done_q;
    logic                       armed_q;
    logic [ROW_W-1:0]           row_q, row_d;
    logic                       drop_err_q, drop_err_d;
    logic [COLS*OP_WIDTH-1:0]   snap_q [ROWS];
    logic [COLS*OP_WIDTH-1:0]   row_word;

    logic done_rise;
    logic hs;
    logic last_row;
    logic last_hs;
    logic capture;

    // armed_q masks the first cycle after reset so a level already high is not an edge
    assign done_rise = compute_done & ~done_q & armed_q;
    assign hs        = out_valid & out_ready;
    assign last_row  = (row_q == ROW_W'(ROWS - 1));
    assign last_hs   = hs & last_row;
    assign capture   = done_rise & ((state_q == IDLE) | last_hs);

`ifdef SYSTOLIC_DRAIN_SAT_EN
    localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic                          sat_seen_q, sat_seen_d;
    logic                          sat_beat;
    logic [OP_WIDTH-1:0]           elem;
    logic [OP_WIDTH-OUT_WIDTH:0]   elem_hi;

    assign sat_seen = sat_seen_q;
`else
    logic unused_hi;

    assign unused_hi = ^row_word;
    assign sat_seen  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            armed_q    <= 1'b0;
            row_q      <= '0;
            drop_err_q <= 1'b0;
`ifdef SYSTOLIC_DRAIN_SAT_EN
            sat_seen_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            done_q     <= compute_done;
            armed_q    <= 1'b1;
            row_q      <= row_d;
            drop_err_q <= drop_err_d;
`ifdef SYSTOLIC_DRAIN_SAT_EN
            sat_seen_q <= sat_seen_d;
`endif
        end
    end

    // Snapshot content is irrelevant outside DRAIN, so it carries no reset
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int r = 0; r < ROWS; r++) begin
                snap_q[r] <= output_matrix[r*COLS*OP_WIDTH +: COLS*OP_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        drop_err_d = drop_err_q | (out_valid & done_rise & ~last_hs);
        case (state_q)
            IDLE:    if (done_rise) state_d = DRAIN;
            DRAIN:   if (last_hs && !done_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (capture) begin
            row_d = '0;
        end else if (hs) begin
            row_d = last_row ? '0 : row_q + ROW_W'(1);
        end
`ifdef SYSTOLIC_DRAIN_SAT_EN
        sat_seen_d = sat_seen_q | (hs & sat_beat);
`endif
    end

    always_comb begin
        out_valid = (state_q == DRAIN);
        busy      = out_valid;
        out_row   = row_q;
        out_last  = out_valid & last_row;
        drop_err  = drop_err_q;
        row_word  = snap_q[row_q];
        out_data  = '0;
`ifdef SYSTOLIC_DRAIN_SAT_EN
        sat_beat  = 1'b0;
        elem      = '0;
        elem_hi   = '0;
`endif
        for (int c = 0; c < COLS; c++) begin
`ifdef SYSTOLIC_DRAIN_SAT_EN
            elem    = row_word[c*OP_WIDTH +: OP_WIDTH];
            elem_hi = elem[OP_WIDTH-1:OUT_WIDTH-1];
            // Value fits when every bit from the narrow sign bit upward agrees
            if ((|elem_hi) && !(&elem_hi)) begin
                out_data[c*OUT_WIDTH +: OUT_WIDTH] = elem[OP_WIDTH-1] ? SAT_MIN : SAT_MAX;
                sat_beat = out_valid;
            end else begin
                out_data[c*OUT_WIDTH +: OUT_WIDTH] = elem[OUT_WIDTH-1:0];
            end
`else
            out_data[c*OUT_WIDTH +: OUT_WIDTH] = row_word[c*OP_WIDTH +: OUT_WIDTH];
`endif
        end
        if (!out_valid) begin
            out_data = '0;
        end
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb/tb_systolic_result_drain.sv - randomized self-checking bench for systolic_result_drain
module tb_systolic_result_drain;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int OPW  = 48;
    localparam int OUTW = 16;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      compute_done = 1'b0;
    logic                      out_ready = 1'b0;
    logic [ROWS*COLS*OPW-1:0]  output_matrix = '0;
    logic                      out_valid, out_last, busy, drop_err, sat_seen;
    logic [COLS*OUTW-1:0]      out_data;
    logic [1:0]                out_row;

    int     errors = 0;
    int     checks = 0;
    int     idx = 0;
    bit     exp_sat = 1'b0;
    longint cur [ROWS][COLS];
    longint nxt [ROWS][COLS];

    always #5 clk = ~clk;

    systolic_result_drain #(
        .ROWS(ROWS), .COLS(COLS), .OP_WIDTH(OPW), .OUT_WIDTH(OUTW)
    ) dut (
        .clk(clk), .rst(rst), .compute_done(compute_done), .output_matrix(output_matrix),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
        .out_last(out_last), .busy(busy), .drop_err(drop_err), .sat_seen(sat_seen)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit clamps(input longint v);
`ifdef SYSTOLIC_DRAIN_SAT_EN
        return (v > 32767) || (v < -32768);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] lane(input longint v);
        logic [63:0] w;
`ifdef SYSTOLIC_DRAIN_SAT_EN
        if (v > 32767)  return 16'h7fff;
        if (v < -32768) return 16'h8000;
`endif
        w = v;
        return w[15:0];
    endfunction

    function automatic logic [63:0] exp_row(input int r);
        logic [63:0] d;
        for (int c = 0; c < COLS; c++) d[c*OUTW +: OUTW] = lane(cur[r][c]);
        return d;
    endfunction

    function automatic bit row_clamps(input int r);
        bit any = 1'b0;
        for (int c = 0; c < COLS; c++) any |= clamps(cur[r][c]);
        return any;
    endfunction

    function automatic longint rand_elem();
        logic [63:0] w;
        if ($urandom_range(0, 1) == 1) begin
            w = {$urandom(), $urandom()};
            return longint'($signed(w[47:0]));
        end
        return longint'($urandom_range(0, 80000)) - 40000;
    endfunction

    // kind 0: element = r*COLS+c, 1: random, 2: all seven
    task automatic fill(input int kind);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                nxt[r][c] = (kind == 0) ? longint'(r*COLS + c) : (kind == 1) ? rand_elem() : 64'd7;
    endtask

    task automatic load();
        logic [63:0] w;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                w = nxt[r][c];
                output_matrix[(r*COLS+c)*OPW +: OPW] = w[47:0];
            end
    endtask

    task automatic start();
        load();
        compute_done = 1'b1;
        step();
        compute_done = 1'b0;
        cur = nxt;
        idx = 0;
        chk("start_valid", out_valid, 1);
        chk("start_busy", busy, 1);
    endtask

    task automatic beat(input bit rdy);
        bit hs, was_valid;
        was_valid = out_valid;
        if (out_valid) begin
            chk("beat_in_range", idx < ROWS, 1);
            if (idx < ROWS) begin
                chk("beat_row", out_row, idx);
                chk("beat_data", out_data, exp_row(idx));
                chk("beat_last", out_last, idx == ROWS-1);
            end
        end
        out_ready = rdy;
        hs = out_valid && rdy;
        if (hs && idx < ROWS && row_clamps(idx)) exp_sat = 1'b1;
        step();
        if (hs) idx++;
        else if (was_valid) chk("stall_hold_valid", out_valid, 1);
    endtask

    // mode 0: ready always, 1: ready 1,0,0 repeating, 2: random ready
    task automatic drain(input int mode);
        int cyc = 0;
        while (idx < ROWS && cyc < 60) begin
            beat(mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1)));
            cyc++;
        end
        out_ready = 1'b0;
        chk("drained_rows", idx, ROWS);
        chk("idle_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("sat_seen", sat_seen, exp_sat);
    endtask

    initial begin
        rst = 1'b0;
        compute_done = 1'b1;
        repeat (3) step();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_last", out_last, 0);
        chk("rst_row", out_row, 0);
        chk("rst_data", out_data, 0);
        chk("rst_drop", drop_err, 0);
        chk("rst_sat", sat_seen, 0);

        rst = 1'b1;
        repeat (3) step();
        chk("no_edge_valid", out_valid, 0);
        chk("no_edge_busy", busy, 0);
        compute_done = 1'b0;
        step();

        fill(0);
        start();
        drain(0);
        out_ready = 1'b1;
        repeat (2) step();
        chk("ready_in_idle", out_valid, 0);
        out_ready = 1'b0;

        fill(1);
        start();
        drain(1);

        fill(1);
        start();
        beat(1'b1);
        fill(1);
        load();
        compute_done = 1'b1;
        beat(1'b0);
        compute_done = 1'b0;
        chk("drop_set", drop_err, 1);
        drain(2);
        chk("drop_sticky", drop_err, 1);

        fill(1);
        start();
        beat(1'b1);
        beat(1'b1);
        rst = 1'b0;
        #1;
        exp_sat = 1'b0;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_drop", drop_err, 0);
        step();
        rst = 1'b1;
        repeat (2) step();
        fill(1);
        start();
        drain(2);

        fill(1);
        start();
        repeat (3) beat(1'b1);
        fill(2);
        load();
        compute_done = 1'b1;
        beat(1'b1);
        compute_done = 1'b0;
        cur = nxt;
        idx = 0;
        chk("b2b_valid", out_valid, 1);
        chk("b2b_row", out_row, 0);
        chk("b2b_data", out_data, 64'h0007_0007_0007_0007);
        chk("b2b_drop", drop_err, 0);
        drain(0);

        fill(1);
        nxt[0][0] = 64'h1_2345;
        nxt[0][1] = -70000;
        start();
        chk("sat_before_accept", sat_seen, exp_sat);
`ifdef SYSTOLIC_DRAIN_SAT_EN
        chk("narrow_lane0", out_data[15:0], 16'h7fff);
        chk("narrow_lane1", out_data[31:16], 16'h8000);
`else
        chk("narrow_lane0", out_data[15:0], 16'h2345);
        chk("narrow_lane1", out_data[31:16], 16'hee90);
`endif
        beat(1'b1);
`ifdef SYSTOLIC_DRAIN_SAT_EN
        chk("narrow_sat_seen", sat_seen, 1);
`else
        chk("narrow_sat_seen", sat_seen, 0);
`endif
        drain(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
